// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared async-FIFO helpers used by both the read and write pointer blocks.
// - FIFO_ADDRSIZE / FIFO_DEPTH : default address width and DEPTH = 1 << ADDRSIZE.
// - bin2gray / gray2bin        : pointer code conversions.
//   They work on a PTR_MAX_W-bit container. Callers zero-extend the value
//   going in and slice the low bits of the result.
package fifo_rd_ctrl_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned FIFO_DEPTH    = 1 << FIFO_ADDRSIZE;
  localparam int unsigned PTR_MAX_W     = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO.
// Ports:
//   rclk_i, rrst_ni   read clock and async active-low reset
//   rq2_wptr_i        Gray write pointer, already synchronised into rclk_i
//   rdata_i           combinational memory data at raddr_o
//   rready_i          consumer accepts rdata_o this cycle
//   raddr_o           memory read address
//   rptr_o            registered Gray read pointer, sent to the write domain
//   rempty_o          memory holds no unfetched word
//   rvalid_o/rdata_o  registered show-ahead output stage
//   rlevel_o          words held: unfetched memory words plus the output register
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                rclk_i,
  input  logic                rrst_ni,
  input  logic [ADDRSIZE:0]   rq2_wptr_i,
  input  logic [DATASIZE-1:0] rdata_i,
  input  logic                rready_i,
  output logic [ADDRSIZE-1:0] raddr_o,
  output logic [ADDRSIZE:0]   rptr_o,
  output logic                rempty_o,
  output logic                rvalid_o,
  output logic [DATASIZE-1:0] rdata_o,
  output logic [ADDRSIZE:0]   rlevel_o
);

  logic [ADDRSIZE:0]   rbin_q,   rbin_d;
  logic [ADDRSIZE:0]   rptr_q,   rptr_d;
  logic                rempty_q, rempty_d;
  logic                rvalid_q, rvalid_d;
  logic [DATASIZE-1:0] rdata_q,  rdata_d;

  logic                 fetch;
  logic [PTR_MAX_W-1:0] rgray_w, wbin_w;
  logic                 unused_hi;

  // Pull a word from memory whenever one exists and the output slot is free
  // or being emptied this cycle. Doing both in one cycle gives 1 word/clock.
  assign fetch   = !rempty_q && (!rvalid_q || rready_i);
  assign rgray_w = bin2gray(PTR_MAX_W'(rbin_d));
  assign wbin_w  = gray2bin(PTR_MAX_W'(rq2_wptr_i));
  assign unused_hi = ^{rgray_w[PTR_MAX_W-1:ADDRSIZE+1], wbin_w[PTR_MAX_W-1:ADDRSIZE+1]};

  always_comb begin
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    rptr_d   = rgray_w[ADDRSIZE:0];
    // This compares the next pointer with the current synchronised write
    // pointer. Empty can therefore lag one cycle after a write arrives, but it
    // never clears while no word is available.
    rempty_d = (rgray_w[ADDRSIZE:0] == rq2_wptr_i);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (fetch) begin
      rvalid_d = 1'b1;
      rdata_d  = rdata_i;
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign raddr_o  = rbin_q[ADDRSIZE-1:0];
  assign rptr_o   = rptr_q;
  assign rempty_o = rempty_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  // Subtraction wraps modulo 2^(ADDRSIZE+1). The MSB of the pointer lets a
  // full memory (difference of DEPTH) be told apart from an empty one.
  assign rlevel_o = (wbin_w[ADDRSIZE:0] - rbin_q) + {{ADDRSIZE{1'b0}}, rvalid_q};

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   wptr;
  logic [DW-1:0] rdata_i;
  logic          rready;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [AW:0]   rlevel;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wbin;
  logic [DW-1:0] sb_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdata_i = mem[raddr];

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk_i     (clk),
    .rrst_ni    (rrst_n),
    .rq2_wptr_i (wptr),
    .rdata_i    (rdata_i),
    .rready_i   (rready),
    .raddr_o    (raddr),
    .rptr_o     (rptr),
    .rempty_o   (rempty),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rlevel_o   (rlevel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Write-side model: store the word, advance the pointer, and expect the word out.
  task automatic push(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    sb_q.push_back(d);
    wbin = wbin + 1'b1;
    wptr = gray(wbin);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && !rvalid) break;
      step();
    end
    chk("drain", 32'(sb_q.size() == 0 && !rvalid), 32'd1);
  endtask

  // Score each transfer just before the edge that completes it.
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (rrst_n && rvalid && rready) begin
      if (sb_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_data", 32'(rdata), 32'(e));
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rrst_n = 1'b0; wptr = '0; wbin = '0; rready = 1'b0;
    step(2);
    chk("rst_empty",  32'(rempty), 32'd1);
    chk("rst_valid",  32'(rvalid), 32'd0);
    chk("rst_raddr",  32'(raddr),  32'd0);
    chk("rst_rptr",   32'(rptr),   32'd0);
    chk("rst_rdata",  32'(rdata),  32'd0);
    chk("rst_level",  32'(rlevel), 32'd0);
    rrst_n = 1'b1;
    step();

    // Burst read of three words.
    rready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("b_empty_n",  32'(rempty), 32'd1);
    step();
    chk("b_empty_n1", 32'(rempty), 32'd0);
    chk("b_valid_n1", 32'(rvalid), 32'd0);
    step();
    chk("b_valid_n2", 32'(rvalid), 32'd1);
    chk("b_data_n2",  32'(rdata),  32'hA1);
    chk("b_level_n2", 32'(rlevel), 32'd3);
    step(3);
    chk("b_valid_end", 32'(rvalid), 32'd0);
    chk("b_empty_end", 32'(rempty), 32'd1);
    chk("b_rptr_end",  32'(rptr),   32'b00010);

    // Backpressure.
    rready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    step(4);
    chk("bp_data",  32'(rdata),  32'hB1);
    chk("bp_valid", 32'(rvalid), 32'd1);
    chk("bp_raddr", 32'(raddr),  32'd4);
    chk("bp_level", 32'(rlevel), 32'd3);
    rready = 1'b1;
    step(3);
    rready = 1'b0;
    chk("bp_valid_end", 32'(rvalid), 32'd0);
    chk("bp_sb_left",   32'(sb_q.size()), 32'd0);
    chk("bp_raddr_end", 32'(raddr), 32'd6);

    // Wrap after sixteen reads, then fill to DEPTH+1 words held.
    rready = 1'b1;
    for (int i = 6; i < DEPTH; i++) push(8'(8'h10 + i));
    wait_drain();
    chk("w_rptr16",  32'(rptr),  32'b11000);
    chk("w_raddr16", 32'(raddr), 32'd0);
    rready = 1'b0;
    push(8'h5A);
    chk("w_wptr17", 32'(wptr), 32'b11001);
    step(2);
    chk("w_valid", 32'(rvalid), 32'd1);
    chk("w_data",  32'(rdata),  32'h5A);
    chk("w_raddr", 32'(raddr),  32'd1);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h60 + i));
    #1;
    chk("w_level_max", 32'(rlevel), 32'(DEPTH + 1));
    rready = 1'b1;
    wait_drain();
    chk("w_level_0", 32'(rlevel), 32'd0);

    // Empty boundary: the last word leaves as the next one arrives.
    rready = 1'b0;
    push(8'hC1);
    step(2);
    chk("e_valid1", 32'(rvalid), 32'd1);
    chk("e_data1",  32'(rdata),  32'hC1);
    rready = 1'b1;
    push(8'hC2);
    step();
    chk("e_no_spur", 32'(rvalid), 32'd0);
    chk("e_empty_n", 32'(rempty), 32'd0);
    step();
    chk("e_valid2", 32'(rvalid), 32'd1);
    chk("e_data2",  32'(rdata),  32'hC2);
    step();
    chk("e_once",   32'(rvalid), 32'd0);
    chk("e_empty",  32'(rempty), 32'd1);
    rready = 1'b0;
    chk("e_sb_left", 32'(sb_q.size()), 32'd0);

    // Reset mid-operation, asserted between clock edges.
    push(8'hD1); push(8'hD2);
    step(3);
    chk("r_valid_pre", 32'(rvalid), 32'd1);
    chk("r_level_pre", 32'(rlevel), 32'd2);
    @(posedge clk); #3;
    rrst_n = 1'b0; wptr = '0; wbin = '0; sb_q.delete();
    #1;
    chk("r_valid", 32'(rvalid), 32'd0);
    chk("r_empty", 32'(rempty), 32'd1);
    chk("r_raddr", 32'(raddr),  32'd0);
    chk("r_rptr",  32'(rptr),   32'd0);
    chk("r_rdata", 32'(rdata),  32'd0);
    chk("r_level", 32'(rlevel), 32'd0);
    step(2);
    rrst_n = 1'b1;
    chk("r_raddr_rel", 32'(raddr), 32'd0);
    push(8'hE1);
    step(2);
    chk("r_valid_post", 32'(rvalid), 32'd1);
    chk("r_data_post",  32'(rdata),  32'hE1);
    chk("r_raddr_post", 32'(raddr),  32'd1);
    rready = 1'b1;
    wait_drain();
    rready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller for the team's asynchronous FIFO; pairs with the write-side memory/pointer logic.
- Consumes the write pointer already synchronised into the read domain and generates the memory read address and Gray read pointer.
- Produces the empty flag, an occupancy count, and a registered show-ahead output stage with a valid/ready handshake toward the consumer.

Parameters:
- DATASIZE, 8, data width.
- ADDRSIZE, 4, memory address width; DEPTH = 1 << ADDRSIZE.

Ports:
- rclk_i  in  1  read-domain clock.
- rrst_ni  in  1  asynchronous reset, active-low.
- rq2_wptr_i  in  ADDRSIZE+1  Gray write pointer, already 2-flop synchronised into rclk_i.
- rdata_i  in  DATASIZE  combinational memory read data at raddr_o.
- rready_i  in  1  consumer accepts rdata_o this cycle.
- raddr_o  out  ADDRSIZE  memory read address.
- rptr_o  out  ADDRSIZE+1  Gray read pointer, sent to the write-domain synchroniser.
- rempty_o  out  1  memory holds no unfetched word.
- rvalid_o  out  1  rdata_o holds a valid word.
- rdata_o  out  DATASIZE  registered output data.
- rlevel_o  out  ADDRSIZE+1  words held: memory plus output register.

Behaviour:
- Reset (async assert, sync release): rbin=0, rptr_o=0, raddr_o=0, rempty_o=1, rvalid_o=0, rdata_o=0. rlevel_o follows the formula below once reset releases.
- Internal state: binary read counter rbin[ADDRSIZE:0]. raddr_o = rbin[ADDRSIZE-1:0]. rptr_o is a register holding gray(rbin).
- fetch = !rempty_o && (!rvalid_o || rready_i).
- rbinnext = rbin + fetch, modulo 2^(ADDRSIZE+1). rgraynext = (rbinnext>>1) ^ rbinnext.
- Each clock: rbin <= rbinnext; rptr_o <= rgraynext; rempty_o <= (rgraynext == rq2_wptr_i).
- Output stage:
  - If fetch: rdata_o <= rdata_i, rvalid_o <= 1.
  - Else if rvalid_o && rready_i: rvalid_o <= 0, rdata_o holds its value.
  - Else: hold.
- Handshake:
  - A word transfers on any cycle with rvalid_o && rready_i.
  - rdata_o and rvalid_o are stable while rvalid_o && !rready_i.
  - Consume and refetch in the same cycle gives back-to-back throughput of 1 word/clock.
- Latency: a word whose write pointer arrives at rq2_wptr_i in cycle N:
  - rempty_o drops at N+1;
  - rvalid_o rises at N+2 if the output stage is free.
- rempty_o is pessimistic: it may stay high for one cycle after the write arrives; it never falsely deasserts.
- Wrap-around: raddr_o wraps DEPTH-1 -> 0. The rbin MSB toggles on every DEPTH reads, so full/empty stay distinguishable on the write side.
- rlevel_o = (gray2bin(rq2_wptr_i) - rbin) mod 2^(ADDRSIZE+1) + rvalid_o. Maximum value is DEPTH+1. It is combinational from registered inputs.
- A fetch while rempty_o=1 never happens; rready_i with rvalid_o=0 has no effect.
- Reset mid-transfer discards the output word immediately. The write domain must be reset in the same window (system rule).

Decomposition:
- Shared async-FIFO package holds:
  - the gray2bin and bin2gray functions (also used by the write-pointer block);
  - the DEPTH localparam convention.
- No sub-module; the output register stage stays inline.
- The 2-flop pointer synchroniser is instantiated outside this block, at the FIFO top.

Test Plan:
All cases use ADDRSIZE=4, DATASIZE=8, and a behavioural memory model driving rdata_i.
1. Reset: hold rrst_ni=0 with rq2_wptr_i=0 -> rempty_o=1, rvalid_o=0, raddr_o=0, rptr_o=0, rdata_o=0, rlevel_o=0. Assert rrst_ni low asynchronously mid-cycle -> outputs return to these values without a clock edge.
2. Burst read: mem[0..2]=A1,A2,A3, rq2_wptr_i=5'b00010 (gray 3), rready_i=1.
   - rempty_o falls at +1; rvalid_o rises at +2.
   - rdata_o = A1, A2, A3 on consecutive cycles, then rvalid_o=0 and rempty_o=1.
   - Final rptr_o=5'b00010.
3. Backpressure: same setup with rready_i=0.
   - Exactly one fetch: rdata_o=A1 held, raddr_o=1, rlevel_o=3.
   - Raising rready_i for 3 cycles drains A2 and A3 in order, with no duplicates or drops.
4. Wrap: after consuming 16 words, rptr_o=5'b11000 (gray 16) and raddr_o=0. rq2_wptr_i=5'b11001 (gray 17) with mem[0]=5A -> rdata_o=5A, raddr_o=1.
5. Empty boundary: the last word is consumed in the same cycle rq2_wptr_i advances by one.
   - No spurious rvalid_o before rempty_o falls.
   - The new word appears exactly once.
6. Reset mid-operation: with rvalid_o=1 and rlevel_o=2, pulse rrst_ni low -> all outputs at reset values immediately; the first fetch after release reads from raddr_o=0.
